alien_sprite_drawer: RTL and testbench

ALIEN_SPRITE_DRAWER -- requirements
Module: alien_sprite_drawer

---
 rtl/alien_sprite_drawer_if.sv | 23 ++
 rtl/alien_sprite_drawer.sv | 125 ++++++++++++
 tb/tb_alien_sprite_drawer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alien_sprite_drawer_if.sv
// Signal bundle between the alien movement logic, the sprite drawer and the VGA adapter.
// The master side supplies the alien position; the slave side is the drawer.
interface alien_sprite_drawer_if;
    logic [7:0] alien_x;
    logic [6:0] alien_y;
    logic       redraw;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output alien_x, alien_y, redraw,
        input  vga_x, vga_y, colour, plot, busy, done
    );

    modport slave (
        input  alien_x, alien_y, redraw,
        output vga_x, vga_y, colour, plot, busy, done
    );
endinterface

// File: rtl/alien_sprite_drawer.sv
// Repaints an 8x4 alien sprite: erases the last drawn position, then draws at the new one.
// One pixel per cycle, with clipping at the screen edges.
module alien_sprite_drawer #(
    parameter logic [2:0]  SPRITE_COLOUR = 3'b010,
    parameter int unsigned SCREEN_W      = 160,
    parameter int unsigned SCREEN_H      = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    alien_sprite_drawer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [7:0] ROW0 = 8'b00111100;
    localparam logic [7:0] ROW1 = 8'b01111110;
    localparam logic [7:0] ROW2 = 8'b11011011;
    localparam logic [7:0] ROW3 = 8'b10100101;
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    state_t     r_state;
    logic [7:0] r_old_x, r_new_x;
    logic [6:0] r_old_y, r_new_y;
    logic       r_valid;
    logic [4:0] r_cnt;

    logic       w_trigger;
    logic [2:0] w_dx;
    logic [1:0] w_dy;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_on_screen;
    logic [7:0] w_row;
    logic       w_bit;

    assign w_trigger = !r_valid || bus.redraw ||
                       (bus.alien_x != r_old_x) || (bus.alien_y != r_old_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_old_x <= '0;
            r_old_y <= '0;
            r_new_x <= '0;
            r_new_y <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_new_x <= bus.alien_x;
                        r_new_y <= bus.alien_y;
                        r_cnt   <= '0;
                        r_state <= r_valid ? ERASE : DRAW;
                    end
                end
                // cnt wraps 31->0 on its own, so DRAW starts from pixel 0 after ERASE
                ERASE: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= DRAW;
                end
                DRAW: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= DONE;
                end
                DONE: begin
                    r_old_x <= r_new_x;
                    r_old_y <= r_new_y;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_dx     = r_cnt[2:0];
    assign w_dy     = r_cnt[4:3];
    assign w_base_x = (r_state == ERASE) ? r_old_x : r_new_x;
    assign w_base_y = (r_state == ERASE) ? r_old_y : r_new_y;
    // One extra bit so that sums past the right/bottom edge are detected, not wrapped
    assign w_sum_x     = {1'b0, w_base_x} + {6'd0, w_dx};
    assign w_sum_y     = {1'b0, w_base_y} + {6'd0, w_dy};
    assign w_on_screen = (w_sum_x < X_LIM) && (w_sum_y < Y_LIM);

    always_comb begin
        case (w_dy)
            2'd0:    w_row = ROW0;
            2'd1:    w_row = ROW1;
            2'd2:    w_row = ROW2;
            default: w_row = ROW3;
        endcase
    end

    assign w_bit = w_row[3'd7 - w_dx];

    always_comb begin
        bus.vga_x  = '0;
        bus.vga_y  = '0;
        bus.colour = '0;
        bus.plot   = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (r_state)
            ERASE: begin
                bus.vga_x = w_sum_x[7:0];
                bus.vga_y = w_sum_y[6:0];
                bus.plot  = w_on_screen;
                bus.busy  = 1'b1;
            end
            DRAW: begin
                bus.vga_x  = w_sum_x[7:0];
                bus.vga_y  = w_sum_y[6:0];
                bus.colour = w_bit ? SPRITE_COLOUR : 3'b000;
                bus.plot   = w_on_screen;
                bus.busy   = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alien_sprite_drawer.sv
// Directed bench for alien_sprite_drawer: draw-only, move, mid-pass input change,
// edge clipping, reset mid-erase and continuous redraw.
module tb_alien_sprite_drawer;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alien_sprite_drawer_if bus ();

    alien_sprite_drawer #(
        .SPRITE_COLOUR(3'b010),
        .SCREEN_W     (160),
        .SCREEN_H     (120)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] spr [4];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 0);
        check({tag, ".plot"}, 32'(bus.plot), 0);
        check({tag, ".done"}, 32'(bus.done), 0);
        check({tag, ".vga_x"}, 32'(bus.vga_x), 0);
        check({tag, ".colour"}, 32'(bus.colour), 0);
    endtask

    task automatic check_done(input string tag);
        check({tag, ".done"}, 32'(bus.done), 1);
        check({tag, ".busy"}, 32'(bus.busy), 0);
        check({tag, ".plot"}, 32'(bus.plot), 0);
        check({tag, ".vga_y"}, 32'(bus.vga_y), 0);
    endtask

    // Checks 32 pixel cycles starting at the current sample; ends sampling the cycle after
    task automatic run_pass(input bit erase, input int bx, input int by, input int mid_y,
                            input string tag, output int plots);
        int sx, sy, dx, dy, ep, ec;
        logic [7:0] rowv;
        plots = 0;
        for (int c = 0; c < 32; c++) begin
            dx = c % 8;
            dy = c / 8;
            sx = bx + dx;
            sy = by + dy;
            ep = (sx < 160 && sy < 120) ? 1 : 0;
            rowv = spr[dy];
            ec = (!erase && rowv[7 - dx]) ? 2 : 0;
            check($sformatf("%s.busy[%0d]", tag, c), 32'(bus.busy), 1);
            check($sformatf("%s.plot[%0d]", tag, c), 32'(bus.plot), 32'(ep));
            check($sformatf("%s.x[%0d]", tag, c), 32'(bus.vga_x), 32'(sx % 256));
            check($sformatf("%s.y[%0d]", tag, c), 32'(bus.vga_y), 32'(sy % 128));
            check($sformatf("%s.col[%0d]", tag, c), 32'(bus.colour), 32'(ec));
            check($sformatf("%s.done[%0d]", tag, c), 32'(bus.done), 0);
            if (bus.plot) plots++;
            if (mid_y >= 0 && c == 10) bus.alien_y = 7'(mid_y);
            step();
        end
    endtask

    initial begin
        int np;
        n_cmp = 0;
        n_err = 0;
        spr[0] = 8'b00111100;
        spr[1] = 8'b01111110;
        spr[2] = 8'b11011011;
        spr[3] = 8'b10100101;

        reset = 1'b1;
        bus.alien_x = 8'd34;
        bus.alien_y = 7'd15;
        bus.redraw  = 1'b0;
        step();
        step();
        check_idle("reset");

        // Draw-only first repaint
        reset = 1'b0;
        step();
        run_pass(0, 34, 15, -1, "first_draw", np);
        check("first_draw.plots", 32'(np), 32);
        check_done("first_done");
        step();
        check_idle("first_idle");
        step();
        check_idle("first_stays_idle");

        // Move right by one: erase old, draw new
        bus.alien_x = 8'd35;
        step();
        run_pass(1, 34, 15, -1, "move_erase", np);
        check("move_erase.plots", 32'(np), 32);
        run_pass(0, 35, 15, -1, "move_draw", np);
        check_done("move_done");
        step();
        check_idle("move_idle");
        step();
        check_idle("move_stays_idle");

        // alien_y changes mid-DRAW; pass finishes at the sampled target
        bus.alien_x = 8'd36;
        step();
        run_pass(1, 35, 15, -1, "mid_erase", np);
        run_pass(0, 36, 15, 19, "mid_draw", np);
        check_done("mid_done");
        step();
        check_idle("mid_idle");
        step();
        run_pass(1, 36, 15, -1, "y_erase", np);
        run_pass(0, 36, 19, -1, "y_draw", np);
        check_done("y_done");
        step();
        check_idle("y_idle");

        // Bottom-right clipping
        bus.alien_x = 8'd155;
        bus.alien_y = 7'd118;
        step();
        run_pass(1, 36, 19, -1, "clip_erase", np);
        run_pass(0, 155, 118, -1, "clip_draw", np);
        check("clip_draw.plots", 32'(np), 10);
        check_done("clip_done");
        step();
        check_idle("clip_idle");

        // Reset at pixel 10 of ERASE
        bus.alien_x = 8'd100;
        bus.alien_y = 7'd50;
        step();
        for (int i = 0; i < 10; i++) step();
        check("rst_mid.busy", 32'(bus.busy), 1);
        check("rst_mid.x", 32'(bus.vga_x), 155 + 2);
        reset = 1'b1;
        step();
        check_idle("rst_after");
        reset = 1'b0;
        step();
        run_pass(0, 100, 50, -1, "rst_redraw", np);
        check_done("rst_done");
        step();
        check_idle("rst_idle");

        // redraw held high: back-to-back identical repaints
        bus.redraw = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            run_pass(1, 100, 50, -1, $sformatf("rd%0d_erase", k), np);
            run_pass(0, 100, 50, -1, $sformatf("rd%0d_draw", k), np);
            check_done($sformatf("rd%0d_done", k));
            step();
            check_idle($sformatf("rd%0d_idle", k));
            if (k == 2) bus.redraw = 1'b0;
            step();
        end
        check_idle("rd_end_idle");
        step();
        check_idle("rd_end_stays_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
